parking_lane_arbiter: RTL

PARKING_LANE_ARBITER -- requirements
Module: parking_lane_arbiter

---
 rtl/parking_lane_arbiter_pkg.sv | 24 ++
 rtl/parking_lane_arbiter_occupancy_counter.sv | 71 +++++++
 rtl/parking_lane_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/parking_lane_arbiter_pkg.sv
// Shared types and constants for the parking lane arbiter.
package parking_lane_arbiter_pkg;

  // Grant timer width; TIMEOUT_CYCLES must fit in it.
  localparam int TIMER_W  = 16;
  // Settle dead-time counter width; SETTLE_CYCLES must fit in it.
  localparam int SETTLE_W = 8;
  // Occupancy counter width.
  localparam int OCC_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IN  = 2'd1,
    ST_GRANT_OUT = 2'd2,
    ST_SETTLE    = 2'd3
  } state_t;

  // Lane direction; the value doubles as the dir_in output level.
  typedef enum logic {
    DIR_EXIT  = 1'b0,
    DIR_ENTRY = 1'b1
  } dir_t;

endpackage

// File: rtl/parking_lane_arbiter_occupancy_counter.sv
// Saturating up/down vehicle counter with registered full/empty flags and a
// sticky error flag (saturation attempt or an externally reported stray pass).
module occupancy_counter
  import parking_lane_arbiter_pkg::*;
#(
  parameter int CAPACITY = 200
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_err,
  output logic [OCC_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_err;

  logic             w_at_cap;
  logic             w_at_zero;
  logic             w_inc_ok;
  logic             w_dec_ok;
  logic             w_sat;
  logic [OCC_W-1:0] w_count_next;

  assign w_at_cap  = (r_count == CAP);
  assign w_at_zero = (r_count == '0);
  assign w_inc_ok  = i_inc & ~w_at_cap;
  assign w_dec_ok  = i_dec & ~w_at_zero;
  assign w_sat     = (i_inc & w_at_cap) | (i_dec & w_at_zero);

  // Next count: a blocked step at either rail leaves the count unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_inc_ok && !w_dec_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (w_dec_ok && !w_inc_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Count and flags update together so full/empty never lag the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_full  <= (w_count_next == CAP);
      r_empty <= (w_count_next == '0);
      if (w_sat || i_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_err   = r_err;

endmodule

// File: rtl/parking_lane_arbiter.sv
// Single-lane barrier arbiter: grants the shared lane to entry or exit,
// round-robin on ties, closes on pass or timeout, then enforces a settle gap.
module parking_lane_arbiter
  import parking_lane_arbiter_pkg::*;
#(
  parameter int CAPACITY       = 200,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_req,
  input  logic       out_req,
  input  logic       pass,
  output logic       gate_open,
  output logic       dir_in,
  output logic [7:0] occupancy,
  output logic       lot_full,
  output logic       lot_empty,
  output logic       timeout,
  output logic       count_err
);

  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              r_state;
  dir_t                r_last_served;
  logic [TIMER_W-1:0]  r_timer;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic                r_gate_open;
  logic                r_dir_in;
  logic                r_timeout;

  logic w_in_elig;
  logic w_out_elig;
  logic w_grant_entry;
  logic w_in_grant;
  logic w_out_grant;
  logic w_timer_done;
  logic w_inc;
  logic w_dec;
  logic w_stray_pass;

  // Entry is blocked while the lot is full; exit is always eligible.
  assign w_in_elig  = in_req & ~lot_full;
  assign w_out_elig = out_req;
  // On a tie, serve the direction that did not go last.
  assign w_grant_entry = w_in_elig & (~w_out_elig | (r_last_served == DIR_EXIT));

  assign w_in_grant   = (r_state == ST_GRANT_IN);
  assign w_out_grant  = (r_state == ST_GRANT_OUT);
  assign w_timer_done = (r_timer == TIMER_LAST);

  assign w_inc        = w_in_grant & pass;
  assign w_dec        = w_out_grant & pass;
  assign w_stray_pass = pass & ~(w_in_grant | w_out_grant);

  // Lane FSM with registered barrier, direction and timeout outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_last_served <= DIR_ENTRY;
      r_timer       <= '0;
      r_settle_cnt  <= '0;
      r_gate_open   <= 1'b0;
      r_dir_in      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_elig || w_out_elig) begin
            r_timer     <= '0;
            r_gate_open <= 1'b1;
            if (w_grant_entry) begin
              r_state  <= ST_GRANT_IN;
              r_dir_in <= 1'b1;
            end else begin
              r_state  <= ST_GRANT_OUT;
              r_dir_in <= 1'b0;
            end
          end
        end
        ST_GRANT_IN, ST_GRANT_OUT: begin
          // Only pass or expiry closes the lane; a pass wins over expiry.
          if (pass || w_timer_done) begin
            r_state       <= ST_SETTLE;
            r_settle_cnt  <= '0;
            r_gate_open   <= 1'b0;
            r_dir_in      <= 1'b0;
            r_last_served <= w_in_grant ? DIR_ENTRY : DIR_EXIT;
            if (!pass) begin
              r_timeout <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gate_open <= 1'b0;
          r_dir_in    <= 1'b0;
        end
      endcase
    end
  end

  occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occupancy_counter (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .i_err   (w_stray_pass),
    .o_count (occupancy),
    .o_full  (lot_full),
    .o_empty (lot_empty),
    .o_err   (count_err)
  );

  assign gate_open = r_gate_open;
  assign dir_in    = r_dir_in;
  assign timeout   = r_timeout;

endmodule
